mem_access_guard: RTL and testbench

//  Registered, parametrised successor to the combinational address checker. Sits between EX/MEM
//  and the DM/bridge. Checks each load/store against NUM_REGIONS configurable windows, with
//  per-region read/write permission, alignment and whole-access containment checks.

---
 rtl/mem_access_guard_pkg.sv | 52 +++++
 rtl/mem_access_guard_region_match.sv | 27 ++
 rtl/mem_access_guard.sv | 163 ++++++++++++++++
 tb/tb_mem_access_guard.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_guard_pkg.sv
// ============================================================================
// Module      : mem_access_guard_pkg
// Description : Shared access-check codes, DM mode encodings and window
//               defaults used by the memory access guard.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_access_guard_pkg;

    // Validity bit positions and whole-code values
    localparam int AC_MISALIGN = 0;
    localparam int AC_RANGE    = 1;
    localparam int AC_PERM     = 2;
    localparam logic [2:0] AC_OK      = 3'b000;
    localparam logic [2:0] AC_ILLEGAL = 3'b111;

    // Permission bit positions inside each {W,R} pair
    localparam int PERM_R = 0;
    localparam int PERM_W = 1;

    typedef enum logic [2:0] {
        DM_W = 3'b000,
        DM_H = 3'b001,
        DM_B = 3'b010
    } dm_mode_e;

    // Default bridge/memory windows, region 0 in the LSBs
    localparam logic [127:0] DEF_REGION_BASE  = {32'h0000_3000, 32'h0000_7F10,
                                                 32'h0000_7F00, 32'h0000_0000};
    localparam logic [127:0] DEF_REGION_LIMIT = {32'h0000_4FFF, 32'h0000_7F1B,
                                                 32'h0000_7F0B, 32'h0000_2FFF};
    localparam logic [7:0]   DEF_REGION_PERM  = {2'b01, 2'b11, 2'b11, 2'b11};

    typedef struct packed {
        logic [2:0] validity;
        logic [2:0] region;
    } mag_rsp_t;

    // Access size in bytes; 0 marks an unknown mode
    function automatic logic [2:0] mode_size(input logic [2:0] mode);
        case (mode)
            DM_W:    mode_size = 3'd4;
            DM_H:    mode_size = 3'd2;
            DM_B:    mode_size = 3'd1;
            default: mode_size = 3'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_guard_region_match.sv
// ============================================================================
// Module      : mag_region_match
// Description : Combinational containment test of one access against one
//               inclusive address window.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mag_region_match #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] limit,
    output logic              hit
);

    // One extra bit so an access running past the top of memory cannot alias low
    logic [ADDR_W:0] w_last;

    assign w_last = {1'b0, addr} + {{(ADDR_W-2){1'b0}}, size} - {{ADDR_W{1'b0}}, 1'b1};
    assign hit    = (size != 3'd0) && (addr >= base) && (w_last <= {1'b0, limit});

endmodule

`default_nettype wire

// File: rtl/mem_access_guard.sv
// ============================================================================
// Module      : mem_access_guard
// Description : Registered load/store window, alignment and permission checker
//               with first-fault capture and saturating fault counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_access_guard
    import mem_access_guard_pkg::*;
#(
    parameter int                             ADDR_W       = 32,
    parameter int                             NUM_REGIONS  = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE  = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_LIMIT = DEF_REGION_LIMIT,
    parameter logic [NUM_REGIONS*2-1:0]       REGION_PERM  = DEF_REGION_PERM,
    parameter int                             FCNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_mode,
    input  logic              req_we,
    input  logic              stall,
    input  logic              fault_ack,
    output logic              rsp_valid,
    output logic [2:0]        rsp_validity,
    output logic [2:0]        rsp_region,
    output logic              fault_pending,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [2:0]        fault_code,
    output logic              fault_we,
    output logic [FCNT_W-1:0] fault_count
);

    logic [2:0]             w_size;
    logic                   w_misalign;
    logic [NUM_REGIONS-1:0] w_hit;
    logic                   w_any_hit;
    logic [2:0]             w_region;
    logic [1:0]             w_perm;
    logic                   w_allowed;
    mag_rsp_t               w_rsp;
    logic                   w_fault;

    logic                   r_rsp_valid;
    logic [2:0]             r_rsp_validity;
    logic [2:0]             r_rsp_region;
    logic                   r_rsp_new;
    logic [ADDR_W-1:0]      r_rsp_addr;
    logic                   r_rsp_we;
    logic                   r_fault_pending;
    logic [ADDR_W-1:0]      r_fault_addr;
    logic [2:0]             r_fault_code;
    logic                   r_fault_we;
    logic [FCNT_W-1:0]      r_fault_count;

    genvar g;
    generate
        for (g = 0; g < NUM_REGIONS; g++) begin : g_region
            mag_region_match #(
                .ADDR_W (ADDR_W)
            ) u_match (
                .addr  (req_addr),
                .size  (w_size),
                .base  (REGION_BASE[g*ADDR_W +: ADDR_W]),
                .limit (REGION_LIMIT[g*ADDR_W +: ADDR_W]),
                .hit   (w_hit[g])
            );
        end
    endgenerate

    always_comb begin
        w_size     = mode_size(req_mode);
        w_misalign = ((req_mode == DM_W) && (req_addr[1:0] != 2'b00)) ||
                     ((req_mode == DM_H) && req_addr[0]);
        w_region   = 3'd0;
        w_perm     = 2'b00;
        // Scan downwards so the lowest matching index is the one left standing
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_region = 3'(i);
                w_perm   = REGION_PERM[2*i +: 2];
            end
        end
        w_any_hit = |w_hit;
        w_allowed = req_we ? w_perm[PERM_W] : w_perm[PERM_R];

        w_rsp = '0;
        if (w_size == 3'd0) begin
            w_rsp.validity = AC_ILLEGAL;
        end else begin
            w_rsp.validity[AC_MISALIGN] = w_misalign;
            w_rsp.validity[AC_RANGE]    = ~w_any_hit;
            w_rsp.validity[AC_PERM]     = w_any_hit & ~w_allowed;
            w_rsp.region                = w_any_hit ? w_region : 3'd0;
        end
    end

    // Response stage; r_rsp_new marks a response that has not yet been seen by fault logic
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_validity <= AC_OK;
            r_rsp_region   <= 3'd0;
            r_rsp_new      <= 1'b0;
            r_rsp_addr     <= '0;
            r_rsp_we       <= 1'b0;
        end else if (stall) begin
            r_rsp_new      <= 1'b0;
        end else begin
            r_rsp_new      <= 1'b1;
            r_rsp_valid    <= req_valid;
            r_rsp_addr     <= req_addr;
            r_rsp_we       <= req_we;
            if (req_valid) begin
                r_rsp_validity <= w_rsp.validity;
                r_rsp_region   <= w_rsp.region;
            end else begin
                r_rsp_validity <= AC_OK;
                r_rsp_region   <= 3'd0;
            end
        end
    end

    assign w_fault = r_rsp_new & r_rsp_valid & (r_rsp_validity != AC_OK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault_pending <= 1'b0;
            r_fault_addr    <= '0;
            r_fault_code    <= AC_OK;
            r_fault_we      <= 1'b0;
            r_fault_count   <= '0;
        end else begin
            // An acknowledge frees the capture slot in the same cycle a new fault arrives
            if (w_fault && (!r_fault_pending || fault_ack)) begin
                r_fault_pending <= 1'b1;
                r_fault_addr    <= r_rsp_addr;
                r_fault_code    <= r_rsp_validity;
                r_fault_we      <= r_rsp_we;
            end else if (fault_ack) begin
                r_fault_pending <= 1'b0;
            end
            if (w_fault && (r_fault_count != {FCNT_W{1'b1}})) begin
                r_fault_count <= r_fault_count + FCNT_W'(1);
            end
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_validity  = r_rsp_validity;
    assign rsp_region    = r_rsp_region;
    assign fault_pending = r_fault_pending;
    assign fault_addr    = r_fault_addr;
    assign fault_code    = r_fault_code;
    assign fault_we      = r_fault_we;
    assign fault_count   = r_fault_count;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_guard.sv
// ============================================================================
// Module      : tb_mem_access_guard
// Description : Scoreboard bench for mem_access_guard with directed vectors.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_guard;
    import mem_access_guard_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [2:0]  req_mode;
    logic        req_we;
    logic        stall;
    logic        fault_ack;
    logic        rsp_valid;
    logic [2:0]  rsp_validity;
    logic [2:0]  rsp_region;
    logic        fault_pending;
    logic [31:0] fault_addr;
    logic [2:0]  fault_code;
    logic        fault_we;
    logic [7:0]  fault_count;

    typedef struct {
        logic [2:0] v;
        logic [2:0] r;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic s_edge_stall = 1'b0;

    mem_access_guard u_dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_mode      (req_mode),
        .req_we        (req_we),
        .stall         (stall),
        .fault_ack     (fault_ack),
        .rsp_valid     (rsp_valid),
        .rsp_validity  (rsp_validity),
        .rsp_region    (rsp_region),
        .fault_pending (fault_pending),
        .fault_addr    (fault_addr),
        .fault_code    (fault_code),
        .fault_we      (fault_we),
        .fault_count   (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a fresh response exists after any unstalled edge with rsp_valid high
    always @(posedge clk) s_edge_stall <= stall;

    always @(negedge clk) begin
        if (reset === 1'b0 && s_edge_stall === 1'b0 && rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_validity), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_validity", 32'(rsp_validity), 32'(e.v));
                check("rsp_region", 32'(rsp_region), 32'(e.r));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [2:0] m, input logic we,
                         input logic [2:0] ev, input logic [2:0] er);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_mode = m; req_we = we;
        stall = 1'b0; fault_ack = 1'b0;
        e.v = ev; e.r = er;
        q.push_back(e);
    endtask

    task automatic idle(input logic ack);
        @(negedge clk);
        req_valid = 1'b0; stall = 1'b0; fault_ack = ack;
    endtask

    task automatic stall_cycle(input logic [31:0] a, input logic [2:0] m, input logic we);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_mode = m; req_we = we;
        stall = 1'b1; fault_ack = 1'b0;
    endtask

    task automatic check_fault(input string tag, input logic p, input logic [31:0] a,
                               input logic [2:0] c, input logic we, input logic [7:0] n);
        check({tag, "_pending"}, 32'(fault_pending), 32'(p));
        check({tag, "_addr"}, fault_addr, a);
        check({tag, "_code"}, 32'(fault_code), 32'(c));
        check({tag, "_we"}, 32'(fault_we), 32'(we));
        check({tag, "_count"}, 32'(fault_count), 32'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_validity"}, 32'(rsp_validity), 32'd0);
        check({tag, "_rsp_region"}, 32'(rsp_region), 32'd0);
        check_fault(tag, 1'b0, 32'd0, 3'd0, 1'b0, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_mode = '0;
        req_we = 1'b0; stall = 1'b0; fault_ack = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Aligned store inside region 0
        issue(32'h2004, DM_W, 1'b1, 3'b000, 3'd0);
        idle(1'b0); idle(1'b0);
        check_fault("t1", 1'b0, 32'd0, 3'd0, 1'b0, 8'd0);

        // Misaligned word crossing the region 0 limit, then a clean region 1 store
        issue(32'h2FFE, DM_W, 1'b0, 3'b011, 3'd0);
        issue(32'h7F08, DM_W, 1'b1, 3'b000, 3'd1);
        idle(1'b0); idle(1'b0);
        check_fault("t2", 1'b1, 32'h2FFE, 3'b011, 1'b0, 8'd1);
        idle(1'b1); idle(1'b0);
        check_fault("t2_ack", 1'b0, 32'h2FFE, 3'b011, 1'b0, 8'd1);

        // Asynchronous reset between clock edges clears the counter
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("reset_pulse");
        @(negedge clk);
        reset = 1'b0;

        // Store into read-only region 3
        issue(32'h3000, DM_W, 1'b1, 3'b100, 3'd3);
        idle(1'b0); idle(1'b0);
        check_fault("t3", 1'b1, 32'h3000, 3'b100, 1'b1, 8'd1);

        // Second fault while pending leaves the capture alone
        issue(32'h7FFF, DM_B, 1'b0, 3'b010, 3'd0);
        idle(1'b0); idle(1'b0);
        check_fault("t4_hold", 1'b1, 32'h3000, 3'b100, 1'b1, 8'd2);

        // Acknowledge coincides with a new fault
        issue(32'h0001, DM_H, 1'b0, 3'b001, 3'd0);
        idle(1'b1); idle(1'b0);
        check_fault("t4_ack", 1'b1, 32'h0001, 3'b001, 1'b0, 8'd3);

        // Stall holds a faulting response; the dropped request never shows and counts once
        issue(32'h7F11, DM_W, 1'b1, 3'b001, 3'd2);
        stall_cycle(32'h3000, DM_W, 1'b1);
        stall_cycle(32'h3000, DM_W, 1'b1);
        check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        check("stall_rsp_validity", 32'(rsp_validity), 32'b001);
        check("stall_rsp_region", 32'(rsp_region), 32'd2);
        idle(1'b0); idle(1'b0);
        check_fault("stall", 1'b1, 32'h0001, 3'b001, 1'b0, 8'd4);

        // Wrap past the top of memory and an illegal mode
        issue(32'hFFFF_FFFE, DM_W, 1'b0, 3'b011, 3'd0);
        issue(32'h0000_0100, 3'b111, 1'b0, 3'b111, 3'd0);
        idle(1'b0); idle(1'b0);
        check_fault("t5", 1'b1, 32'h0001, 3'b001, 1'b0, 8'd6);

        for (int i = 0; i < 300; i++) begin
            issue(32'(i) << 2, 3'b111, 1'b0, 3'b111, 3'd0);
        end
        idle(1'b0); idle(1'b0);
        check_fault("sat", 1'b1, 32'h0001, 3'b001, 1'b0, 8'hFF);

        // Reset asserted mid-stall while a fault is pending
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h3000; req_mode = DM_W; req_we = 1'b1; stall = 1'b1;
        #2 reset = 1'b1;
        #1 check_all_zero("reset_stall");
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; req_valid = 1'b0;

        issue(32'h2004, DM_W, 1'b1, 3'b000, 3'd0);
        idle(1'b0); idle(1'b0);
        check_fault("post_reset", 1'b0, 32'd0, 3'd0, 1'b0, 8'd0);

        idle(1'b0); idle(1'b0);
        check("queue_drain", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
